// File: rtl/key_sw_conditioner.sv
// Conditions the DE-board push buttons and slide switches: 2-flop sync, per-bit
// debounce, per-key auto-repeat press pulses and a switch-change strobe.
module key_sw_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic [3:0] key_raw,
    input  logic [9:0] sw_raw,
    output logic [3:0] key_0_conduit_end_export,
    output logic [9:0] sw_0_conduit_end_export,
    output logic [3:0] key_press,
    output logic       sw_change
);

    localparam int NB   = 14;
    localparam int NK   = 4;
    localparam int CW   = $clog2(DEBOUNCE_CYCLES);
    localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = $clog2(TMAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] DLY_LAST = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PER_LAST = TW'(REPEAT_PERIOD - 1);
    // Keys idle high (active-low buttons), switches idle low.
    localparam logic [NB-1:0] RST_VAL  = {10'h000, 4'hF};

    typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, RPT = 2'd2} state_e;

    logic [NB-1:0] raw;
    logic [NB-1:0] meta_q, sync_q, stable_q, stable_d, upd;
    logic [CW-1:0] cnt_q [NB];
    logic [CW-1:0] cnt_d [NB];
    logic [9:0]    sw_prev_q;
    logic          sw_change_q, sw_change_d;
    logic [NK-1:0] key_fall;
    state_e        state_q [NK];
    state_e        state_d [NK];
    logic [TW-1:0] timer_q [NK];
    logic [TW-1:0] timer_d [NK];
    logic [NK-1:0] press_q, press_d;

    assign raw = {sw_raw, key_raw};

    always_comb begin
        upd = '0;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            if (sync_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) upd[i] = 1'b1;
                else                      cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    assign stable_d    = stable_q ^ upd;
    // A press is the debounced key flipping to 0 on this very edge.
    assign key_fall    = upd[NK-1:0] & ~sync_q[NK-1:0];
    assign sw_change_d = |(stable_q[NB-1:NK] ^ sw_prev_q);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            meta_q      <= RST_VAL;
            sync_q      <= RST_VAL;
            stable_q    <= RST_VAL;
            sw_prev_q   <= '0;
            sw_change_q <= 1'b0;
            for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
        end else begin
            meta_q      <= raw;
            sync_q      <= meta_q;
            stable_q    <= stable_d;
            sw_prev_q   <= stable_q[NB-1:NK];
            sw_change_q <= sw_change_d;
            for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            press_q <= '0;
            for (int i = 0; i < NK; i++) begin
                state_q[i] <= IDLE;
                timer_q[i] <= '0;
            end
        end else begin
            press_q <= press_d;
            for (int i = 0; i < NK; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
            end
        end
    end

    // Release (stable key back at 1) wins over a coincident timer expiry.
    always_comb begin
        for (int i = 0; i < NK; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = '0;
            case (state_q[i])
                IDLE: begin
                    if (key_fall[i]) state_d[i] = DELAY;
                end
                DELAY: begin
                    if (stable_q[i])                 state_d[i] = IDLE;
                    else if (timer_q[i] == DLY_LAST) state_d[i] = RPT;
                    else                             timer_d[i] = timer_q[i] + 1'b1;
                end
                RPT: begin
                    if (stable_q[i])                 state_d[i] = IDLE;
                    else if (timer_q[i] != PER_LAST) timer_d[i] = timer_q[i] + 1'b1;
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    always_comb begin
        press_d = '0;
        for (int i = 0; i < NK; i++) begin
            case (state_q[i])
                IDLE:    press_d[i] = key_fall[i];
                DELAY:   press_d[i] = !stable_q[i] && (timer_q[i] == DLY_LAST);
                RPT:     press_d[i] = !stable_q[i] && (timer_q[i] == PER_LAST);
                default: press_d[i] = 1'b0;
            endcase
        end
    end

    assign key_0_conduit_end_export = stable_q[NK-1:0];
    assign sw_0_conduit_end_export  = stable_q[NB-1:NK];
    assign key_press                = press_q;
    assign sw_change                = sw_change_q;

endmodule

// File: tb/tb_key_sw_conditioner.sv
// Directed bench for key_sw_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=3; cycle t means "sampled #1 after edge t".
module tb_key_sw_conditioner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key_raw = 4'hF;
    logic [9:0] sw_raw = 10'h000;
    logic [3:0] key_exp_o;
    logic [9:0] sw_exp_o;
    logic [3:0] key_press;
    logic       sw_change;

    int vecs = 0;
    int errs = 0;

    key_sw_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3)
    ) dut (
        .clk_clk                 (clk),
        .reset_reset_n           (rst_n),
        .key_raw                 (key_raw),
        .sw_raw                  (sw_raw),
        .key_0_conduit_end_export(key_exp_o),
        .sw_0_conduit_end_export (sw_exp_o),
        .key_press               (key_press),
        .sw_change               (sw_change)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rep_pulse(int t, int rel);
        return (t == 6) || (t >= 16 && t <= rel + 6 && ((t - 16) % 3) == 0);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; key_raw = 4'hF; sw_raw = 10'h000;
        repeat (3) tick();
        vecs++;
        if (key_exp_o !== 4'hF || sw_exp_o !== 10'h000 || key_press !== 4'h0 || sw_change !== 1'b0) begin
            errs++;
            $display("FAIL reset: key=%h sw=%h press=%h swc=%b, want F 000 0 0", key_exp_o, sw_exp_o, key_press, sw_change);
        end
        rst_n = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_single_press();
        logic [3:0] ek, ep;
        key_raw = 4'b1110;
        for (int t = 1; t <= 30; t++) begin
            tick();
            ek = (t >= 6 && t < 12) ? 4'b1110 : 4'hF;
            ep = (t == 6) ? 4'b0001 : 4'h0;
            vecs++;
            if (key_exp_o !== ek || key_press !== ep) begin
                errs++;
                $display("FAIL single_press t=%0d: key=%h press=%h, want %h %h", t, key_exp_o, key_press, ek, ep);
            end
            if (t == 6) key_raw = 4'hF;
        end
    endtask

    task automatic test_glitch();
        for (int t = 0; t < 30; t++) begin
            key_raw = ((t % 6) < 3) ? 4'b1101 : 4'hF;
            tick();
            vecs++;
            if (key_exp_o !== 4'hF || key_press !== 4'h0) begin
                errs++;
                $display("FAIL glitch t=%0d: key=%h press=%h, want F 0", t, key_exp_o, key_press);
            end
        end
        key_raw = 4'hF;
        repeat (8) tick();
    endtask

    task automatic test_auto_repeat(input int rel);
        logic [3:0] ek, ep;
        key_raw = 4'b1011;
        for (int t = 1; t <= rel + 12; t++) begin
            tick();
            ek = (t >= 6 && t < rel + 6) ? 4'b1011 : 4'hF;
            ep = rep_pulse(t, rel) ? 4'b0100 : 4'h0;
            vecs++;
            if (key_exp_o !== ek || key_press !== ep) begin
                errs++;
                $display("FAIL auto_repeat rel=%0d t=%0d: key=%h press=%h, want %h %h", rel, t, key_exp_o, key_press, ek, ep);
            end
            if (t == rel) key_raw = 4'hF;
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] ep;
        key_raw = 4'b0110;
        for (int t = 1; t <= 20; t++) begin
            tick();
            ep = (t == 6) ? 4'b1001 : 4'h0;
            vecs++;
            if (key_press !== ep) begin
                errs++;
                $display("FAIL simultaneous t=%0d: press=%h, want %h", t, key_press, ep);
            end
            if (t == 8) key_raw = 4'hF;
        end
    endtask

    task automatic test_switch(input logic [9:0] from_v, input logic [9:0] to_v);
        logic [9:0] es;
        sw_raw = to_v;
        for (int t = 1; t <= 9; t++) begin
            tick();
            es = (t >= 6) ? to_v : from_v;
            vecs++;
            if (sw_exp_o !== es || sw_change !== (t == 7)) begin
                errs++;
                $display("FAIL switch %h->%h t=%0d: sw=%h swc=%b, want %h %b", from_v, to_v, t, sw_exp_o, sw_change, es, (t == 7));
            end
        end
    endtask

    task automatic test_reset_mid_repeat();
        logic [3:0] ek, ep;
        logic [9:0] es;
        key_raw = 4'b0111;
        repeat (20) tick();
        #2;
        rst_n = 1'b0;
        sw_raw = 10'h2A0;
        #1;
        vecs++;
        if (key_exp_o !== 4'hF || sw_exp_o !== 10'h000 || key_press !== 4'h0 || sw_change !== 1'b0) begin
            errs++;
            $display("FAIL async_reset: key=%h sw=%h press=%h swc=%b, want F 000 0 0", key_exp_o, sw_exp_o, key_press, sw_change);
        end
        repeat (3) begin
            tick();
            vecs++;
            if (key_exp_o !== 4'hF || key_press !== 4'h0 || sw_change !== 1'b0) begin
                errs++;
                $display("FAIL held_reset: key=%h press=%h swc=%b, want F 0 0", key_exp_o, key_press, sw_change);
            end
        end
        rst_n = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            ek = (t >= 6) ? 4'b0111 : 4'hF;
            ep = (t == 6) ? 4'b1000 : 4'h0;
            es = (t >= 6) ? 10'h2A0 : 10'h000;
            vecs++;
            if (key_exp_o !== ek || key_press !== ep || sw_exp_o !== es || sw_change !== (t == 7)) begin
                errs++;
                $display("FAIL post_reset t=%0d: key=%h press=%h sw=%h swc=%b, want %h %h %h %b",
                         t, key_exp_o, key_press, sw_exp_o, sw_change, ek, ep, es, (t == 7));
            end
        end
        key_raw = 4'hF;
        repeat (10) tick();
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_glitch();
        test_auto_repeat(40);
        test_auto_repeat(18);
        test_simultaneous();
        test_switch(10'h000, 10'h3FF);
        test_switch(10'h3FF, 10'h005);
        test_reset_mid_repeat();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/key_sw_conditioner.md
KEY_SW_CONDITIONER -- requirements
Module: key_sw_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000; stable-time in clocks (20 ms at 50 MHz); legal range 2..2^24.
REQ-002 SHALL have parameter REPEAT_DELAY, default 25000000; clocks a key is held before auto-repeat starts; legal range >=2.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 5000000; clocks between auto-repeat pulses; legal range >=2.
REQ-004 SHALL have port clk_clk, input, 1 bit; the single clock (50 MHz).
REQ-005 SHALL have port reset_reset_n, input, 1 bit; asynchronous assert, active-low reset.
REQ-006 SHALL have port key_raw, input, 4 bits; push buttons, asynchronous, active-low (0 = pressed).
REQ-007 SHALL have port sw_raw, input, 10 bits; slide switches, asynchronous, active-high.
REQ-008 SHALL have port key_0_conduit_end_export, output, 4 bits; debounced key level, active-low; feeds the soc_system key PIO.
REQ-009 SHALL have port sw_0_conduit_end_export, output, 10 bits; debounced switch level; feeds the soc_system sw PIO.
REQ-010 SHALL have port key_press, output, 4 bits; 1-clock pulse per key on a debounced press or auto-repeat.
REQ-011 SHALL have port sw_change, output, 1 bit; 1-clock pulse when any debounced switch bit changes.

Function
REQ-012 Every raw bit SHALL pass through a 2-flop synchronizer; the sync flops of bit i are "s_i".
REQ-013 Each of the 14 bits SHALL have its own debounce counter, width clog2(DEBOUNCE_CYCLES).
REQ-014 While s_i equals the stable output of bit i, its counter SHALL be held at 0.
REQ-015 While s_i differs from the stable output, the counter SHALL increment each clock.
REQ-016 When the counter is at DEBOUNCE_CYCLES-1 and s_i still differs, the stable output SHALL take s_i on that edge and the counter SHALL clear.
REQ-017 A glitch returning s_i to the stable value before the terminal count SHALL clear the counter with no output change.
REQ-018 Latency from a clean raw edge to the stable-output change SHALL be exactly DEBOUNCE_CYCLES+2 clocks.
REQ-019 Each key SHALL have a repeat FSM with states IDLE, DELAY and REPEAT, plus a shared-width repeat timer.
REQ-020 IDLE->DELAY SHALL occur when the stable key goes 1->0; key_press[i]=1 for that single clock; timer cleared.
REQ-021 In DELAY, when the timer reaches REPEAT_DELAY-1 the FSM SHALL move to REPEAT, pulse key_press[i] and clear the timer.
REQ-022 In REPEAT, the FSM SHALL pulse key_press[i] and clear the timer each time the timer reaches REPEAT_PERIOD-1.
REQ-023 From DELAY or REPEAT, a stable key of 1 (release) SHALL force IDLE with the timer cleared; release has priority over a same-cycle timer expiry, so no pulse is issued.
REQ-024 Keys SHALL be fully independent; simultaneous presses SHALL produce simultaneous pulses.
REQ-025 sw_change SHALL be 1 for exactly one clock on the edge after any stable sw bit changes; multiple bits changing in the same clock SHALL give one pulse.
REQ-026 Timers SHALL saturate/clear as specified and never wrap into a spurious pulse.

Reset
REQ-027 While reset_reset_n=0, all of the following SHALL hold asynchronously:
- key sync flops and key_0_conduit_end_export = 4'hF
- sw sync flops and sw_0_conduit_end_export = 10'h000
- all counters and timers = 0
- all FSMs in IDLE
- key_press = 0, sw_change = 0
REQ-028 Reset asserted mid-debounce or mid-repeat SHALL abort the operation with no pulse.
REQ-029 After deassertion, a key already held low SHALL be debounced normally and produce exactly one initial press pulse.
REQ-030 After deassertion, a switch already high SHALL update after debounce and pulse sw_change once.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-031 key_raw[0] 1->0 clean at cycle 0 -> key_0_conduit_end_export[0]=0 and key_press[0]=1 at cycle 6; no further pulse if released by cycle 12.
REQ-032 key_raw[1] low 3 clocks then high, repeated -> key_0_conduit_end_export stays 4'hF; key_press stays 0.
REQ-033 key_raw[2] held low 40 clocks -> pulses at cycles 6, 16, 19, 22, ...; release -> FSM returns to IDLE and pulses stop.
REQ-034 sw_raw 0->10'h3FF in one clock -> sw_0_conduit_end_export=10'h3FF at cycle 6 with a single sw_change pulse.
REQ-035 Reset asserted during REPEAT, with key still held after release of reset -> outputs at reset values immediately; one press pulse DEBOUNCE_CYCLES+2 clocks after deassertion.
REQ-036 Release coinciding with timer expiry in REPEAT -> no pulse; FSM in IDLE.
